dos_nmi_ctrl: RTL and testbench



---
 rtl/dos_nmi_ctrl_pkg.sv | 16 +
 rtl/dos_nmi_ctrl_z80_m1_detect.sv | 28 ++
 rtl/dos_nmi_ctrl.sv | 133 +++++++++++++
 tb/tb_dos_nmi_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dos_nmi_ctrl_pkg.sv
// Shared definitions for the DOS/NMI controller: FSM state codes (also used for
// port readback) and parameter defaults.
package dos_nmi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_ACTIVE  = 2'b10,
    ST_RELEASE = 2'b11
  } nmi_state_e;

  localparam logic [15:0] NMI_VEC_DEFAULT    = 16'h0066;
  localparam int          M1_TIMEOUT_DEFAULT = 32;
  localparam int          M1_CNT_W           = 6;

endpackage

// File: rtl/dos_nmi_ctrl_z80_m1_detect.sv
// Z80 opcode-fetch detector: m1_n is sampled on zpos and mreq_n on zneg; o_m1f
// pulses for one fclk on the zneg where MREQ first goes active during M1.
module z80_m1_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_zpos,
  input  logic i_zneg,
  input  logic i_m1_n,
  input  logic i_mreq_n,
  output logic o_m1f
);

  logic r_m1_n_reg;
  logic r_mreq_n_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m1_n_reg   <= 1'b1;
      r_mreq_n_reg <= 1'b1;
    end else begin
      if (i_zpos) r_m1_n_reg   <= i_m1_n;
      if (i_zneg) r_mreq_n_reg <= i_mreq_n;
    end
  end

  assign o_m1f = i_zneg & ~r_m1_n_reg & ~i_mreq_n & r_mreq_n_reg;

endmodule

// File: rtl/dos_nmi_ctrl.sv
// Global DOS flag and NMI service FSM for the Z80 memory pagers; all outputs are
// registered on fclk.
module dos_nmi_ctrl
  import dos_nmi_ctrl_pkg::*;
#(
  parameter int          M1_TIMEOUT = M1_TIMEOUT_DEFAULT,
  parameter logic [15:0] NMI_VEC    = NMI_VEC_DEFAULT
) (
  input  logic        i_fclk,
  input  logic        i_rst_n,
  input  logic        i_zpos,
  input  logic        i_zneg,
  input  logic [15:0] i_za,
  input  logic        i_m1_n,
  input  logic        i_mreq_n,
  input  logic [3:0]  i_dos_turn_on,
  input  logic [3:0]  i_dos_turn_off,
  input  logic        i_cpm_n,
  input  logic        i_nmi_button,
  input  logic        i_nmi_exit_stb,
  output logic        o_dos,
  output logic        o_in_nmi,
  output logic        o_nmi_n,
  output logic [1:0]  o_state_rd
);

  localparam logic [M1_CNT_W-1:0] LP_TIMEOUT = M1_CNT_W'(M1_TIMEOUT);
  localparam logic [M1_CNT_W-1:0] LP_REL_ZPOS_LAST = M1_CNT_W'(1);

  nmi_state_e          r_state;
  nmi_state_e          w_state_next;
  logic [M1_CNT_W-1:0] r_cnt;
  logic [M1_CNT_W-1:0] w_cnt_next;
  logic [M1_CNT_W-1:0] w_cnt_inc;
  logic                r_btn_prev;
  logic                w_btn_rise;
  logic                w_m1f;
  logic                r_dos;
  logic                r_in_nmi;
  logic                r_nmi_n;

  z80_m1_detect u_m1_detect (
    .i_clk    (i_fclk),
    .i_rst_n  (i_rst_n),
    .i_zpos   (i_zpos),
    .i_zneg   (i_zneg),
    .i_m1_n   (i_m1_n),
    .i_mreq_n (i_mreq_n),
    .o_m1f    (w_m1f)
  );

  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dos <= 1'b1;
    end else if (!i_cpm_n || (|i_dos_turn_on)) begin
      r_dos <= 1'b1;
    end else if (|i_dos_turn_off) begin
      r_dos <= 1'b0;
    end
  end

  assign w_cnt_inc  = r_cnt + M1_CNT_W'(1);
  assign w_btn_rise = i_nmi_button & ~r_btn_prev;

  // r_cnt counts M1 fetches in REQ and consecutive button-low zpos in RELEASE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_rise) begin
          w_state_next = ST_REQ;
          w_cnt_next   = '0;
        end
      end
      ST_REQ: begin
        if (w_m1f) begin
          w_cnt_next = w_cnt_inc;
          if (i_za == NMI_VEC) begin
            w_state_next = ST_ACTIVE;
          end else if (w_cnt_inc == LP_TIMEOUT) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_ACTIVE: begin
        if (i_nmi_exit_stb) begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
        end
      end
      ST_RELEASE: begin
        if (i_zpos) begin
          if (i_nmi_button) begin
            w_cnt_next = '0;
          end else if (r_cnt == LP_REL_ZPOS_LAST) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Button history resets high so a press held through reset is not an edge.
  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_btn_prev <= 1'b1;
      r_in_nmi   <= 1'b0;
      r_nmi_n    <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_btn_prev <= i_nmi_button;
      r_in_nmi   <= (w_state_next == ST_ACTIVE);
      r_nmi_n    <= (w_state_next != ST_REQ);
    end
  end

  assign o_dos      = r_dos;
  assign o_in_nmi   = r_in_nmi;
  assign o_nmi_n    = r_nmi_n;
  assign o_state_rd = r_state;

endmodule

// File: tb/tb_dos_nmi_ctrl.sv
// Directed self-checking bench for dos_nmi_ctrl; expected output vectors are
// queued when stimulus is applied and checked once the DUT has responded.
module tb_dos_nmi_ctrl;

  logic        fclk = 1'b0;
  logic        rstN;
  logic        zpos = 1'b0;
  logic        zneg = 1'b0;
  logic [15:0] za;
  logic        m1N;
  logic        mreqN;
  logic [3:0]  dosOn;
  logic [3:0]  dosOff;
  logic        cpmN;
  logic        nmiButton;
  logic        nmiExit;
  logic        dos;
  logic        inNmi;
  logic        nmiN;
  logic [1:0]  stateRd;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   ph         = 7;
  logic inNmiSeen;

  dos_nmi_ctrl dut (
    .i_fclk         (fclk),
    .i_rst_n        (rstN),
    .i_zpos         (zpos),
    .i_zneg         (zneg),
    .i_za           (za),
    .i_m1_n         (m1N),
    .i_mreq_n       (mreqN),
    .i_dos_turn_on  (dosOn),
    .i_dos_turn_off (dosOff),
    .i_cpm_n        (cpmN),
    .i_nmi_button   (nmiButton),
    .i_nmi_exit_stb (nmiExit),
    .o_dos          (dos),
    .o_in_nmi       (inNmi),
    .o_nmi_n        (nmiN),
    .o_state_rd     (stateRd)
  );

  always #5 fclk = ~fclk;

  // Z80 clock strobes: 8 fclk per Z80 cycle, changed away from the active edge.
  always @(negedge fclk) begin
    ph   = (ph + 1) % 8;
    zpos = (ph == 0);
    zneg = (ph == 4);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushExp(input string tag, input logic d, input logic inN,
                         input logic nN, input logic [1:0] st);
    exp_t e;
    e.tag = tag;
    e.val = {d, inN, nN, st};
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] obs;
    obs = {dos, inNmi, nmiN, stateRd};
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard empty observed=%b", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("[TB] FAIL %s observed={dos,in_nmi,nmi_n,st}=%b expected=%b",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic waitZpos();
    do @(posedge fclk); while (zpos !== 1'b1);
  endtask

  task automatic waitZneg();
    do @(posedge fclk); while (zneg !== 1'b1);
  endtask

  // One-fclk strobe; returns 1 time unit after the edge that consumed it.
  task automatic applyStimulus(input logic [3:0] on, input logic [3:0] off,
                               input logic ex);
    dosOn   = on;
    dosOff  = off;
    nmiExit = ex;
    @(posedge fclk);
    #1;
    dosOn   = '0;
    dosOff  = '0;
    nmiExit = 1'b0;
  endtask

  task automatic pressButton(input logic v);
    nmiButton = v;
    cycles(1);
  endtask

  // Returns 1 time unit after the zneg edge on which the fetch is detected.
  task automatic doM1Fetch(input logic [15:0] addr);
    za    = addr;
    m1N   = 1'b0;
    mreqN = 1'b1;
    waitZneg();
    #1;
    waitZpos();
    #1;
    mreqN = 1'b0;
    waitZneg();
    #1;
    mreqN = 1'b1;
    m1N   = 1'b1;
  endtask

  initial begin
    rstN      = 1'b0;
    za        = 16'h0000;
    m1N       = 1'b1;
    mreqN     = 1'b1;
    dosOn     = '0;
    dosOff    = '0;
    cpmN      = 1'b1;
    nmiButton = 1'b0;
    nmiExit   = 1'b0;
    inNmiSeen = 1'b0;

    repeat (4) @(posedge fclk);
    #3 rstN = 1'b1;
    @(posedge fclk);
    #1;
    pushExp("reset", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();

    applyStimulus(4'b0000, 4'b0100, 1'b0);
    pushExp("dosOff", 1'b0, 1'b0, 1'b1, 2'b00); checkOutput();
    applyStimulus(4'b0001, 4'b0010, 1'b0);
    pushExp("dosOnWins", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    pushExp("dosOff2", 1'b0, 1'b0, 1'b1, 2'b00); checkOutput();
    cpmN = 1'b0;
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    pushExp("cpmForce", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    pushExp("cpmOffIgnored", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    cpmN = 1'b1;
    cycles(1);
    pushExp("cpmRelease", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();

    pressButton(1'b1);
    pushExp("btnReq", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();
    cycles(3);
    pushExp("reqHold", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();
    doM1Fetch(16'h0066);
    pushExp("vecActive", 1'b1, 1'b1, 1'b1, 2'b10); checkOutput();
    pressButton(1'b0);
    cycles(2);
    pressButton(1'b1);
    cycles(2);
    pushExp("noNest", 1'b1, 1'b1, 1'b1, 2'b10); checkOutput();
    pressButton(1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    pushExp("exitRelease", 1'b1, 1'b0, 1'b1, 2'b11); checkOutput();
    waitZpos();
    #1;
    pushExp("relOneZpos", 1'b1, 1'b0, 1'b1, 2'b11); checkOutput();
    waitZpos();
    #1;
    pushExp("relTwoZpos", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    pushExp("strayExit", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();

    pressButton(1'b1);
    pushExp("toReq", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();
    for (int k = 0; k < 31; k++) begin
      doM1Fetch(16'h1234);
      if (inNmi) inNmiSeen = 1'b1;
    end
    pushExp("fetch31", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();
    doM1Fetch(16'h1234);
    if (inNmi) inNmiSeen = 1'b1;
    pushExp("timeout32", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    compared++;
    assert (inNmiSeen === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL inNmiNever observed=%b expected=0", inNmiSeen);
    end

    pressButton(1'b0);
    pressButton(1'b1);
    pushExp("req2", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();
    for (int k = 0; k < 30; k++) doM1Fetch(16'h1234);
    doM1Fetch(16'h0066);
    pushExp("vecOn31", 1'b1, 1'b1, 1'b1, 2'b10); checkOutput();
    applyStimulus(4'b0000, 4'b1000, 1'b0);
    pushExp("dosOffActive", 1'b0, 1'b1, 1'b1, 2'b10); checkOutput();

    #1 rstN = 1'b0;
    #1;
    pushExp("asyncReset", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    @(posedge fclk);
    #3 rstN = 1'b1;
    cycles(4);
    pushExp("heldAfterReset", 1'b1, 1'b0, 1'b1, 2'b00); checkOutput();
    pressButton(1'b0);
    pressButton(1'b1);
    pushExp("rePress", 1'b1, 1'b0, 1'b0, 2'b01); checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
